// File: rtl/lap_stopwatch.sv
// lap_stopwatch: MM:SS stopwatch with start/stop, lap freeze and clear.
// An internal prescaler produces a count tick every TICK_DIV clocks; the BCD
// count feeds a display register that can be frozen (LAP mode), and the
// displayed value is decoded to four 7-segment digits.
// The control FSM state is exported on dbg_state (0 IDLE, 1 RUN, 2 STOP).
module lap_stopwatch #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int MIN_MAX     = 59,
  parameter int WRAP        = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic [15:0] disp_bcd,
  output logic [27:0] seg,
  output logic [1:0]  dbg_state
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_U = 4'(MIN_MAX % 10);
  localparam logic [15:0] COUNT_MAX = {MAX_T, MAX_U, 4'd5, 4'd9};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ss_prev_q, lap_prev_q;
  logic             mode_q, mode_d;        // 0 = LIVE, 1 = LAP (display frozen)
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      count_q, count_d;      // {min_t, min_u, sec_t, sec_u}
  logic [15:0]      count_inc;
  logic [15:0]      disp_q, disp_d;
  logic             overflow_q, overflow_d;
  logic [27:0]      seg_raw;

  logic ss_rise, lap_rise, tick, at_max, do_clear;

  // Button edge detection; a simultaneous start/stop edge swallows the lap edge.
  always_comb begin
    ss_rise  = start_stop & ~ss_prev_q;
    lap_rise = lap & ~lap_prev_q & ~ss_rise;
    tick     = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    at_max   = (count_q == COUNT_MAX);
    do_clear = (state_q == ST_STOP) && lap_rise && !mode_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_rise) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_rise)                              state_d = ST_STOP;
        else if (tick && at_max && (WRAP == 0))   state_d = ST_STOP;
      end
      ST_STOP: begin
        if (ss_rise)       state_d = ST_RUN;
        else if (do_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    running    = (state_q == ST_RUN);
    lap_active = mode_q;
    overflow   = overflow_q;
    disp_bcd   = disp_q;
    dbg_state  = state_q;
  end

  // BCD cascade increment: sec_units 0-9, sec_tens 0-5, minutes as a BCD pair.
  always_comb begin
    count_inc = count_q;
    if (count_q[3:0] != 4'd9) begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] != 4'd5) begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] != 4'd9) begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_inc[11:8]  = 4'd0;
          count_inc[15:12] = count_q[15:12] + 4'd1;
        end
      end
    end
  end

  // Datapath next state: prescaler, count, display mode, display, overflow.
  always_comb begin
    pre_d      = pre_q;
    count_d    = count_q;
    mode_d     = mode_q;
    overflow_d = tick && at_max;
    disp_d     = mode_q ? disp_q : count_q;

    // Prescaler: restart from zero out of IDLE, keep sub-tick progress across STOP.
    if (state_q == ST_IDLE && ss_rise) pre_d = '0;
    else if (do_clear)                 pre_d = '0;
    else if (state_q == ST_RUN)        pre_d = tick ? '0 : pre_q + 1'b1;

    if (do_clear) begin
      count_d = '0;
    end else if (tick) begin
      if (!at_max)          count_d = count_inc;
      else if (WRAP != 0)   count_d = '0;
    end

    if (state_q == ST_RUN && lap_rise)              mode_d = ~mode_q;
    else if (state_q == ST_STOP && lap_rise && mode_q) mode_d = 1'b0;
  end

  // Datapath registers; button history resets high so a held button gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      mode_q     <= 1'b0;
      pre_q      <= '0;
      count_q    <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;
      mode_q     <= mode_d;
      pre_q      <= pre_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Segment decode of the shown value; non-BCD nibbles are blank.
  always_comb begin
    seg_raw = {seg7(disp_q[15:12]), seg7(disp_q[11:8]), seg7(disp_q[7:4]), seg7(disp_q[3:0])};
    seg     = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch (TICK_DIV=4, MIN_MAX=1). Two instances share
// the stimulus: u_wrap (WRAP=1) is the main subject, u_hold (WRAP=0) is checked
// around the overflow and reset.
module tb_lap_stopwatch;

  logic clk, reset, start_stop, lap;

  logic        w_running, w_lap_active, w_overflow;
  logic [15:0] w_disp;
  logic [27:0] w_seg;
  logic [1:0]  w_state;

  logic        h_running, h_lap_active, h_overflow;
  logic [15:0] h_disp;
  logic [27:0] h_seg;
  logic [1:0]  h_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic        ss;
    logic        lp;
    int          ncyc;
    logic [15:0] disp;
    logic        run;
    logic        lapa;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[12];

  lap_stopwatch #(.TICK_DIV(4), .MIN_MAX(1), .WRAP(1), .SEG_ACT_LOW(0)) u_wrap (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap),
    .running(w_running), .lap_active(w_lap_active), .overflow(w_overflow),
    .disp_bcd(w_disp), .seg(w_seg), .dbg_state(w_state)
  );

  lap_stopwatch #(.TICK_DIV(4), .MIN_MAX(1), .WRAP(0), .SEG_ACT_LOW(0)) u_hold (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap),
    .running(h_running), .lap_active(h_lap_active), .overflow(h_overflow),
    .disp_bcd(h_disp), .seg(h_seg), .dbg_state(h_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [27:0] zeros;
    zeros = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    check({tag, " disp"},       32'(w_disp),       32'h0000);
    check({tag, " seg"},        32'(w_seg),        32'(zeros));
    check({tag, " running"},    32'(w_running),    32'd0);
    check({tag, " lap_active"}, 32'(w_lap_active), 32'd0);
    check({tag, " overflow"},   32'(w_overflow),   32'd0);
    check({tag, " state"},      32'(w_state),      32'd0);
    check({tag, " hold disp"},  32'(h_disp),       32'h0000);
    check({tag, " hold run"},   32'(h_running),    32'd0);
  endtask

  initial begin
    logic [27:0] seg_0159;
    logic [15:0] exp_disp;

    // Stimulus table: ss/lap asserted for the first edge, then released.
    vecs[0]  = '{1'b1, 1'b0, 42,  16'h0010, 1'b1, 1'b0, 2'd1}; // start, 10 ticks
    vecs[1]  = '{1'b1, 1'b0, 100, 16'h0010, 1'b0, 1'b0, 2'd2}; // stop, frozen count
    vecs[2]  = '{1'b1, 1'b0, 3,   16'h0010, 1'b1, 1'b0, 2'd1}; // restart, prescaler kept
    vecs[3]  = '{1'b0, 1'b0, 1,   16'h0011, 1'b1, 1'b0, 2'd1}; // tick after 2 more cycles
    vecs[4]  = '{1'b0, 1'b1, 20,  16'h0011, 1'b1, 1'b1, 2'd1}; // lap: display frozen
    vecs[5]  = '{1'b0, 1'b1, 2,   16'h0016, 1'b1, 1'b0, 2'd1}; // lap again: live
    vecs[6]  = '{1'b0, 1'b1, 2,   16'h0016, 1'b1, 1'b1, 2'd1}; // enter lap
    vecs[7]  = '{1'b1, 1'b1, 2,   16'h0016, 1'b0, 1'b1, 2'd2}; // ss+lap: stop only
    vecs[8]  = '{1'b0, 1'b1, 2,   16'h0017, 1'b0, 1'b0, 2'd2}; // STOP+LAP -> live
    vecs[9]  = '{1'b0, 1'b1, 2,   16'h0000, 1'b0, 1'b0, 2'd0}; // STOP+LIVE -> clear
    vecs[10] = '{1'b0, 1'b1, 2,   16'h0000, 1'b0, 1'b0, 2'd0}; // lap in IDLE: no effect
    vecs[11] = '{1'b1, 1'b0, 6,   16'h0001, 1'b1, 1'b0, 2'd1}; // start from zero

    // Reset with start_stop held through release
    reset = 1'b1; start_stop = 1'b1; lap = 1'b0;
    step(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    step(3);
    check("held ss running", 32'(w_running), 32'd0);
    check("held ss state",   32'(w_state),   32'd0);
    start_stop = 1'b0;
    step(2);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(vecs[i].disp);
      start_stop = vecs[i].ss;
      lap        = vecs[i].lp;
      step(1);
      start_stop = 1'b0;
      lap        = 1'b0;
      if (vecs[i].ncyc > 1) step(vecs[i].ncyc - 1);
      exp_disp = exp_q.pop_front();
      check($sformatf("vec%0d disp", i),       32'(w_disp),       32'(exp_disp));
      check($sformatf("vec%0d running", i),    32'(w_running),    32'(vecs[i].run));
      check($sformatf("vec%0d lap_active", i), 32'(w_lap_active), 32'(vecs[i].lapa));
      check($sformatf("vec%0d state", i),      32'(w_state),      32'(vecs[i].st));
    end

    // Overflow: count reaches 01:59 at 476 cycles after the last start
    step(474);
    check("pre-ovf wrap disp",   32'(w_disp),     32'h0159);
    check("pre-ovf hold disp",   32'(h_disp),     32'h0159);
    check("pre-ovf wrap ovf",    32'(w_overflow), 32'd0);
    step(1);
    check("ovf wrap pulse",      32'(w_overflow), 32'd1);
    check("ovf hold pulse",      32'(h_overflow), 32'd1);
    check("ovf wrap running",    32'(w_running),  32'd1);
    check("ovf hold running",    32'(h_running),  32'd0);
    check("ovf hold state",      32'(h_state),    32'd2);
    step(1);
    seg_0159 = {7'h3F, 7'h06, 7'h6D, 7'h6F};
    check("post-ovf wrap pulse", 32'(w_overflow), 32'd0);
    check("post-ovf hold pulse", 32'(h_overflow), 32'd0);
    check("post-ovf wrap disp",  32'(w_disp),     32'h0000);
    check("post-ovf hold disp",  32'(h_disp),     32'h0159);
    check("post-ovf hold seg",   32'(h_seg),      32'(seg_0159));
    check("post-ovf wrap run",   32'(w_running),  32'd1);

    // Reset mid-run at 01:37 while in lap mode
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    step(389);
    check("mid-run disp", 32'(w_disp), 32'h0137);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    check("mid-run lap_active", 32'(w_lap_active), 32'd1);
    reset = 1'b1;
    step(1);
    check_reset_outputs("mid-run reset");
    reset = 1'b0;
    step(1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
